// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - button indices and default timing shared by the stopwatch core and button conditioner
package stopwatch_pkg;

   localparam int BTN_RUN  = 0;
   localparam int BTN_CLR  = 1;
   localparam int BTN_TMP  = 2;

   localparam int BN_DEF   = 3;
   localparam int MSPN_DEF = 24000;
   localparam int DBN_DEF  = 20;
   localparam int RPD_DEF  = 500;
   localparam int RPP_DEF  = 100;

   // counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stopwatch_debounce_ch.sv
// rtl/stopwatch_debounce_ch.sv - one button: synchroniser, ms-tick debounce, press pulse
// Optional auto-repeat pulses when STOPWATCH_BTN_RPT_EN is defined.
module stopwatch_debounce_ch
   import stopwatch_pkg::*;
#(
   parameter int DBN  = DBN_DEF,
   parameter int BPOL = 1,
   parameter int RPD  = RPD_DEF,
   parameter int RPP  = RPP_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   input  logic i_tick,
   output logic o_lvl,
   output logic o_pls
);

   localparam int DW = cnt_w(DBN);

   logic          w_in;
   logic          w_accept;
   logic          w_rpt;
   logic          r_s1;
   logic          r_sync;
   logic          r_lvl;
   logic          r_pls;
   logic [DW-1:0] r_dcnt;

   assign w_in     = (BPOL != 0) ? i_raw : ~i_raw;
   assign w_accept = i_tick && (r_sync != r_lvl) && (r_dcnt == DW'(DBN - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1   <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_s1   <= w_in;
         r_sync <= r_s1;
      end
   end

   // dcnt counts ms ticks of unbroken disagreement; any agreement restarts it
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dcnt <= '0;
         r_lvl  <= 1'b0;
      end else if (r_sync == r_lvl) begin
         r_dcnt <= '0;
      end else if (i_tick) begin
         if (r_dcnt == DW'(DBN - 1)) begin
            r_lvl  <= r_sync;
            r_dcnt <= '0;
         end else begin
            r_dcnt <= r_dcnt + DW'(1);
         end
      end
   end

`ifdef STOPWATCH_BTN_RPT_EN
   localparam int RW = cnt_w(RPD);

   logic [RW-1:0] r_rcnt;

   // tick that would release the button never produces a repeat
   assign w_rpt = r_lvl && i_tick && !w_accept && (r_rcnt == RW'(RPD - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || !r_lvl) begin
         r_rcnt <= '0;
      end else if (i_tick && !w_accept) begin
         if (r_rcnt == RW'(RPD - 1)) begin
            r_rcnt <= RW'(RPD - RPP);
         end else begin
            r_rcnt <= r_rcnt + RW'(1);
         end
      end
   end
`else
   assign w_rpt = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pls <= 1'b0;
      end else begin
         r_pls <= (w_accept && r_sync) || w_rpt;
      end
   end

   assign o_lvl = r_lvl;
   assign o_pls = r_pls;

endmodule

// File: rtl/stopwatch_buttons.sv
// rtl/stopwatch_buttons.sv - button conditioner: shared ms prescaler plus BN debounce channels
// Auto-repeat pulses are built only when STOPWATCH_BTN_RPT_EN is defined.
module stopwatch_buttons
   import stopwatch_pkg::*;
#(
   parameter int MSPN = MSPN_DEF,
   parameter int BN   = BN_DEF,
   parameter int DBN  = DBN_DEF,
   parameter int BPOL = 1,
   parameter int RPD  = RPD_DEF,
   parameter int RPP  = RPP_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [BN-1:0] btn_raw,
   output logic [BN-1:0] btn_lvl,
   output logic [BN-1:0] btn_pls,
   output logic          ms_tick
);

   localparam int PW = cnt_w(MSPN);

   logic [PW-1:0] r_pcnt;
   logic          r_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_pcnt == PW'(MSPN - 1));
         if (r_pcnt == PW'(MSPN - 1)) begin
            r_pcnt <= '0;
         end else begin
            r_pcnt <= r_pcnt + PW'(1);
         end
      end
   end

   assign ms_tick = r_tick;

   for (genvar gi = 0; gi < BN; gi++) begin : g_ch
      stopwatch_debounce_ch #(
         .DBN  (DBN),
         .BPOL (BPOL),
         .RPD  (RPD),
         .RPP  (RPP)
      ) u_ch (
         .i_clk  (clk),
         .i_rst  (rst),
         .i_raw  (btn_raw[gi]),
         .i_tick (r_tick),
         .o_lvl  (btn_lvl[gi]),
         .o_pls  (btn_pls[gi])
      );
   end

endmodule

// File: tb/tb_stopwatch_buttons.sv
// tb/tb_stopwatch_buttons.sv - random and directed checks of stopwatch_buttons against a behavioural model
module tb_stopwatch_buttons;

   localparam int MSPN = 5;
   localparam int BN   = 3;
   localparam int DBN  = 4;
   localparam int RPD  = 10;
   localparam int RPP  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BN-1:0] btn_raw = '0;
   logic [BN-1:0] raw_inv;
   logic [BN-1:0] lvl_p, pls_p, lvl_n, pls_n;
   logic          tick_p, tick_n;

   assign raw_inv = ~btn_raw;

   always #5 clk = ~clk;

   stopwatch_buttons #(.MSPN(MSPN), .BN(BN), .DBN(DBN), .BPOL(1), .RPD(RPD), .RPP(RPP)) u_dut_p (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .btn_lvl(lvl_p), .btn_pls(pls_p), .ms_tick(tick_p)
   );

   stopwatch_buttons #(.MSPN(MSPN), .BN(BN), .DBN(DBN), .BPOL(0), .RPD(RPD), .RPP(RPP)) u_dut_n (
      .clk(clk), .rst(rst), .btn_raw(raw_inv),
      .btn_lvl(lvl_n), .btn_pls(pls_n), .ms_tick(tick_n)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // model: sync is raw seen two edges ago, tick every MSPN-th edge after reset,
   // a press/release is accepted on the DBN-th strobe seen during an unbroken disagreement
   logic          m_valid = 1'b0;
   logic [BN-1:0] m_s1, m_sync, m_lvl, m_pls;
   logic          m_tick;
   int            m_k;
   int            m_run [BN];
   int            m_rc  [BN];

   always @(posedge clk) begin : p_model
      logic t_old;
      logic lvl_old;
      logic acc;
      if (rst) begin
         m_valid = 1'b1;
         m_s1 = '0; m_sync = '0; m_lvl = '0; m_pls = '0; m_tick = 1'b0; m_k = 0;
         for (int i = 0; i < BN; i++) begin m_run[i] = 0; m_rc[i] = 0; end
      end else begin
         t_old = m_tick;
         for (int i = 0; i < BN; i++) begin
            lvl_old  = m_lvl[i];
            acc      = 1'b0;
            m_pls[i] = 1'b0;
            if (m_sync[i] != m_lvl[i]) begin
               if (t_old) m_run[i]++;
               if (m_run[i] == DBN) begin
                  m_lvl[i] = m_sync[i];
                  m_pls[i] = m_sync[i];
                  m_run[i] = 0;
                  m_rc[i]  = 0;
                  acc      = 1'b1;
               end
            end else begin
               m_run[i] = 0;
            end
`ifdef STOPWATCH_BTN_RPT_EN
            if (!lvl_old) m_rc[i] = 0;
            else if (!acc && t_old) begin
               m_rc[i]++;
               if (m_rc[i] >= RPD && ((m_rc[i] - RPD) % RPP) == 0) m_pls[i] = 1'b1;
            end
`else
            if (lvl_old && acc) m_rc[i] = 0;
`endif
         end
         m_sync = m_s1;
         m_s1   = btn_raw;
         m_k++;
         m_tick = ((m_k % MSPN) == 0);
      end
   end

   task automatic chk(input string nm, input logic [BN-1:0] act, input logic [BN-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b want %b at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_lit(input string nm, input int act, input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   int            pls_cnt  [BN];
   int            pls_cyc  [BN];
   int            rise_cnt [BN];
   int            rise_cyc [BN];
   int            pq [$];
   logic [BN-1:0] lvl_prev;

   always @(negedge clk) begin : p_compare
      cyc++;
      if (m_valid) begin
         chk("lvl_pol1", lvl_p, m_lvl);
         chk("pls_pol1", pls_p, m_pls);
         chk("tick_pol1", {2'b00, tick_p}, {2'b00, m_tick});
         chk("lvl_pol0", lvl_n, m_lvl);
         chk("pls_pol0", pls_n, m_pls);
         chk("tick_pol0", {2'b00, tick_n}, {2'b00, m_tick});
      end
      for (int i = 0; i < BN; i++) begin
         if (pls_p[i] === 1'b1) begin
            pls_cnt[i]++;
            pls_cyc[i] = cyc;
            if (i == 2) pq.push_back(cyc);
         end
         if (lvl_p[i] === 1'b1 && lvl_prev[i] === 1'b0) begin
            rise_cnt[i]++;
            rise_cyc[i] = cyc;
         end
      end
      lvl_prev = lvl_p;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clear_stats();
      for (int i = 0; i < BN; i++) begin
         pls_cnt[i] = 0; pls_cyc[i] = 0; rise_cnt[i] = 0; rise_cyc[i] = 0;
      end
      pq.delete();
   endtask

   initial begin : p_stim
      int t0;
      int npl;
      clear_stats();

      // reset with all buttons held
      rst = 1'b1; btn_raw = '1;
      step(3);
      chk("rst_lvl", lvl_p, '0);
      chk("rst_pls", pls_p, '0);
      chk("rst_tick", {2'b00, tick_p}, '0);
      rst = 1'b0; clear_stats(); t0 = cyc;
      step(16);
      chk("post_rst_lvl_early", lvl_p, '0);
      step(14);
      chk("post_rst_lvl", lvl_p, '1);
      for (int i = 0; i < BN; i++) chk_lit("post_rst_one_pulse", pls_cnt[i], 1, 1);
      chk_lit("post_rst_latency", pls_cyc[0] - t0, 17, 23);
      btn_raw = '0; step(30);

      // clean press on run
      clear_stats(); btn_raw[0] = 1'b1; t0 = cyc;
      step(40);
      chk_lit("press_latency", rise_cyc[0] - t0, 18, 23);
      chk_lit("press_pulse_cycles", pls_cnt[0], 1, 1);
      chk_lit("press_other_pulses", pls_cnt[1] + pls_cnt[2], 0, 0);

      // release: level falls, no pulse
      clear_stats(); btn_raw[0] = 1'b0;
      step(25);
      chk("release_lvl", {2'b00, lvl_p[0]}, '0);
      chk_lit("release_pulses", pls_cnt[0], 0, 0);

      // bouncing clr then stable hold
      clear_stats();
      for (int j = 0; j < 10; j++) begin btn_raw[1] = ~btn_raw[1]; step(3); end
      btn_raw[1] = 1'b1; t0 = cyc;
      step(40);
      chk_lit("bounce_pulses", pls_cnt[1], 1, 1);
      chk_lit("bounce_after_hold", pls_cyc[1] - t0, 18, 23);
      btn_raw[1] = 1'b0; step(30);

      // 14-cycle glitch
      clear_stats(); btn_raw[1] = 1'b1; step(14); btn_raw[1] = 1'b0; step(40);
      chk_lit("glitch_pulses", pls_cnt[1], 0, 0);
      chk_lit("glitch_rises", rise_cnt[1], 0, 0);

      // reset in the middle of a press debounce
      clear_stats(); btn_raw[0] = 1'b1; step(10);
      rst = 1'b1; step(3); rst = 1'b0; t0 = cyc;
      step(30);
      chk_lit("rst_mid_pulses", pls_cnt[0], 1, 1);
      chk_lit("rst_mid_latency", rise_cyc[0] - t0, 18, 23);
      btn_raw[0] = 1'b0; step(30);

      // all buttons at once
      clear_stats(); btn_raw = '1; step(40);
      for (int i = 0; i < BN; i++) chk_lit("simul_pulses", pls_cnt[i], 1, 1);
      chk_lit("simul_same_cycle_1", pls_cyc[1] - pls_cyc[0], 0, 0);
      chk_lit("simul_same_cycle_2", pls_cyc[2] - pls_cyc[0], 0, 0);
      btn_raw = '0; step(30);

      // long hold on tmp
      clear_stats(); btn_raw[2] = 1'b1; step(200); btn_raw[2] = 1'b0; step(40);
      npl = pq.size();
`ifdef STOPWATCH_BTN_RPT_EN
      chk_lit("repeat_count", npl, 9, 9);
      if (npl >= 2) chk_lit("repeat_first_gap", pq[1] - pq[0], 50, 50);
      for (int j = 2; j < npl; j++) chk_lit("repeat_gap", pq[j] - pq[j-1], 20, 20);
`else
      chk_lit("hold_single_pulse", npl, 1, 1);
`endif
      chk("hold_released_lvl", {2'b00, lvl_p[2]}, '0);

      // random bursts with occasional resets
      for (int s = 0; s < 80; s++) begin
         if ($urandom_range(0, 14) == 0) begin
            rst = 1'b1; step($urandom_range(1, 3)); rst = 1'b0;
         end
         btn_raw = BN'($urandom);
         step($urandom_range(1, 30));
      end
      btn_raw = '0; step(30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
